mem_bus_arbiter: RTL

//  Shares the single 128-bit-line, busywait-handshaked data memory between the I-cache (refill reads)
//  and the D-cache (refill reads, dirty writebacks). Sits between both cache controllers and the memory;

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr2.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   arb_state_e : arbiter FSM states
//   OwnerI/OwnerD : which cache port owns the transaction in flight
//   OpRd/OpWr     : latched memory operation
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;

  localparam logic OpRd = 1'b0;
  localparam logic OpWr = 1'b1;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way grant for the I and D cache ports.
//   clock, reset : clock and asynchronous active-high reset
//   i_req_i      : I-port request
//   d_req_i      : D-port request
//   update_i     : arbitration is taking place this clock (pointer may move)
//   grant_d_o    : 1 = D-port wins, 0 = I-port wins (meaningful when a request is present)
// With FIXED_PRI set the D-port always wins; otherwise contention is resolved by a
// pointer that flips after every contended grant. Single requests leave it alone.
module mem_arb_rr2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic update_i,
  output logic grant_d_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (FIXED_PRI) begin
      grant_d_o = d_req_i;
    end else if (i_req_i && d_req_i) begin
      grant_d_o = ptr_q;
    end else begin
      grant_d_o = d_req_i;
    end
    if (update_i && i_req_i && d_req_i) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= OwnerI;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one busywait-handshaked line memory between the I-cache and the D-cache.
//   clock, reset        : clock, asynchronous active-high reset
//   i_read, i_address   : I-cache line read request and block address
//   i_busywait          : I-port request pending / not yet complete
//   d_read, d_write     : D-cache line read / writeback request
//   d_address           : D-cache block address
//   d_writedata         : D-cache writeback line
//   d_busywait          : D-port request pending / not yet complete
//   readdata            : last line read from memory, valid in the owner's completion cycle
//   mem_read, mem_write : memory strobes
//   mem_address         : memory block address
//   mem_writedata       : memory write line
//   mem_readdata        : memory read line
//   mem_busywait        : memory busy
//   timeout_err         : sticky, a transaction spent MAX_WAIT clocks waiting on memory
// One transaction is in flight at a time: IDLE -> ISSUE (1 clk) -> WAIT -> DONE (1 clk).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned MAX_WAIT  = 64,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_writedata,
  output logic              d_busywait,
  output logic [LINE_W-1:0] readdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_writedata,
  input  logic [LINE_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              timeout_err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic i_req, d_req, grant_d;
  logic rd_strobe, wr_strobe;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  mem_arb_rr2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_rr (
    .clock    (clock),
    .reset    (reset),
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .update_i (state_q == StIdle),
    .grant_d_o(grant_d)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          owner_d = grant_d;
          // A simultaneous read and write from the D-cache is served as a write.
          op_d    = (grant_d && d_write) ? OpWr : OpRd;
          addr_d  = grant_d ? d_address : i_address;
          if (grant_d) begin
            wdata_d = d_writedata;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        rd_strobe  = (op_q == OpRd);
        wr_strobe  = (op_q == OpWr);
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        // Strobe follows busywait so memory never re-samples a finished request.
        rd_strobe = (op_q == OpRd) && mem_busywait;
        wr_strobe = (op_q == OpWr) && mem_busywait;
        if (wait_cnt_q != MaxCnt) begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
        if (wait_cnt_d == MaxCnt) begin
          timeout_d = 1'b1;
        end
        if (!mem_busywait) begin
          if (op_q == OpRd) begin
            rdata_d = mem_readdata;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= OwnerI;
      op_q       <= OpRd;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Reset gating makes the strobes drop in the same timestep reset rises.
  assign mem_read      = rd_strobe & ~reset;
  assign mem_write     = wr_strobe & ~reset;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign readdata      = rdata_q;
  assign timeout_err   = timeout_q;

  assign i_busywait = i_req & ~((state_q == StDone) && (owner_q == OwnerI));
  assign d_busywait = d_req & ~((state_q == StDone) && (owner_q == OwnerD));

endmodule
